serial_word_capture: RTL and testbench

// - Downstream consumer of the D flip-flop stage: takes the registered serial bit q (as din) and assembles framed words.
// - Frame on din: start bit (0), WIDTH data bits LSB-first, optional parity bit, stop bit (1).
// - Presents the word in parallel with a one-cycle valid strobe. Flags malformed frames.

---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_word_capture_if.sv | 21 ++
 rtl/serial_word_capture_bit_counter.sv | 35 +++
 rtl/serial_word_capture.sv | 127 ++++++++++++
 tb/tb_serial_word_capture.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared encodings and frame constants for the serial word capture block.
// Optional parity support is selected with the PARITY_CHECK_EN macro.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_word_capture_if.sv
// Serial input and word-output bundle between the bit source and serial_word_capture.
interface serial_word_capture_if #(
  parameter int unsigned WIDTH = 8
);
  logic             din;
  logic             bit_en;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             busy;

  modport master (
    output din, bit_en,
    input  data_out, data_valid, frame_err, busy
  );

  modport slave (
    input  din, bit_en,
    output data_out, data_valid, frame_err, busy
  );
endinterface

// File: rtl/serial_word_capture_bit_counter.sv
// Data-bit counter with synchronous clear and enable.
// tc flags the last data bit of a frame (cnt == WIDTH-1).
module bit_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_word_capture.sv
// Assembles start/data/stop framed words from a strobed serial bit stream.
// Define PARITY_CHECK_EN to insert an even-parity bit between data and stop.
module serial_word_capture
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_word_capture_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             cnt_clear, cnt_en, cnt_tc;
  logic             stop_ok;
`ifdef PARITY_CHECK_EN
  logic             par_err_q, par_err_d;
`endif

  bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

`ifdef PARITY_CHECK_EN
  assign stop_ok = (bus.din == STOP_BIT) && !par_err_q;
`else
  assign stop_ok = (bus.din == STOP_BIT);
`endif

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
`ifdef PARITY_CHECK_EN
    par_err_d    = par_err_q;
`endif
    if (bus.bit_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.din == START_BIT) begin
            state_d   = ST_DATA;
            cnt_clear = 1'b1;
`ifdef PARITY_CHECK_EN
            par_err_d = 1'b0;
`endif
          end
        end
        ST_DATA: begin
          shreg_d = {bus.din, shreg_q[WIDTH-1:1]};
          cnt_en  = 1'b1;
          if (cnt_tc) begin
`ifdef PARITY_CHECK_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        ST_PARITY: begin
          par_err_d = (bus.din != ^shreg_q);
          state_d   = ST_STOP;
        end
`endif
        ST_STOP: begin
          // A 0 here is a framing error, never a new start bit.
          state_d = ST_IDLE;
          if (stop_ok) begin
            data_out_d   = shreg_q;
            data_valid_d = 1'b1;
          end else begin
            frame_err_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end
`endif

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_word_capture.sv
// Directed bench for serial_word_capture (WIDTH=8); honours PARITY_CHECK_EN.
module tb_serial_word_capture;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  int   n_dv = 0;
  int   n_fe = 0;
  int   dv_mark, fe_mark;

  serial_word_capture_if #(.WIDTH(8)) bus ();

  serial_word_capture #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Strobe counters, sampled mid-cycle where outputs are stable.
  always @(negedge clk) begin
    if (bus.data_valid) n_dv++;
    if (bus.frame_err)  n_fe++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // gap idle cycles (bit_en=0, din toggling) precede the strobed bit.
  task automatic strobe(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bus.bit_en = 1'b0;
      bus.din    = ~bus.din;
    end
    @(negedge clk);
    bus.din    = b;
    bus.bit_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic stop_b, input logic par_b,
                            input int gap);
    strobe(1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(w[i], gap);
`ifdef PARITY_CHECK_EN
    strobe(par_b, gap);
`else
    if (par_b === 1'bx) $display("unexpected parity argument");
`endif
    strobe(stop_b, gap);
  endtask

  initial begin
    bus.din    = 1'b1;
    bus.bit_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data_out", 16'(bus.data_out), 16'h00);
    check("reset_valid", 16'(bus.data_valid), 16'h0);
    check("reset_err", 16'(bus.frame_err), 16'h0);
    check("reset_busy", 16'(bus.busy), 16'h0);
    reset = 1'b0;
    strobe(1'b1, 0);
    check("idle_one_busy", 16'(bus.busy), 16'h0);

    // Good frame 8'hA5
    strobe(1'b0, 0);
    check("start_busy", 16'(bus.busy), 16'h1);
    for (int i = 0; i < 8; i++) strobe(i[0] ^ i[2] ? 1'b0 : 1'b1, 0);
`ifdef PARITY_CHECK_EN
    strobe(1'b0, 0);
`endif
    strobe(1'b1, 0);
    check("a5_valid", 16'(bus.data_valid), 16'h1);
    check("a5_data", 16'(bus.data_out), 16'hA5);
    check("a5_err", 16'(bus.frame_err), 16'h0);
    check("a5_busy", 16'(bus.busy), 16'h0);
    strobe(1'b1, 0);
    check("a5_valid_drop", 16'(bus.data_valid), 16'h0);

    // Bad stop bit 8'h3C
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    check("badstop_err", 16'(bus.frame_err), 16'h1);
    check("badstop_valid", 16'(bus.data_valid), 16'h0);
    check("badstop_data", 16'(bus.data_out), 16'hA5);
    check("badstop_busy", 16'(bus.busy), 16'h0);
    strobe(1'b1, 0);
    check("badstop_err_drop", 16'(bus.frame_err), 16'h0);
    check("badstop_idle_busy", 16'(bus.busy), 16'h0);

    // Gapped strobes, frame 8'h81
    send_frame(8'h81, 1'b1, 1'b0, 2);
    check("gap_valid", 16'(bus.data_valid), 16'h1);
    check("gap_data", 16'(bus.data_out), 16'h81);
    @(negedge clk);
    bus.bit_en = 1'b0;
    @(posedge clk);
    #1;
    check("gap_valid_drop", 16'(bus.data_valid), 16'h0);
    check("gap_data_hold", 16'(bus.data_out), 16'h81);

    // Reset after 4 data bits, then full 8'h5A frame
    strobe(1'b0, 0);
    for (int i = 0; i < 4; i++) strobe(1'b1, 0);
    check("midframe_busy", 16'(bus.busy), 16'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy", 16'(bus.busy), 16'h0);
    check("rst_data", 16'(bus.data_out), 16'h00);
    @(negedge clk);
    reset = 1'b0;
    dv_mark = n_dv;
    fe_mark = n_fe;
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    check("5a_valid", 16'(bus.data_valid), 16'h1);
    check("5a_data", 16'(bus.data_out), 16'h5A);
    strobe(1'b1, 0);
    check("5a_pulse_count", 16'(n_dv - dv_mark), 16'd1);
    check("5a_no_err", 16'(n_fe - fe_mark), 16'd0);

    // Back-to-back 8'hFF then 8'h00, no idle bit
    dv_mark = n_dv;
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    check("ff_valid", 16'(bus.data_valid), 16'h1);
    check("ff_data", 16'(bus.data_out), 16'hFF);
    send_frame(8'h00, 1'b1, 1'b0, 0);
    check("00_valid", 16'(bus.data_valid), 16'h1);
    check("00_data", 16'(bus.data_out), 16'h00);
    strobe(1'b1, 0);
    check("b2b_pulse_count", 16'(n_dv - dv_mark), 16'd2);

`ifdef PARITY_CHECK_EN
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check("par_ok_valid", 16'(bus.data_valid), 16'h1);
    check("par_ok_data", 16'(bus.data_out), 16'h07);
    strobe(1'b1, 0);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    check("par_bad_err", 16'(bus.frame_err), 16'h1);
    check("par_bad_valid", 16'(bus.data_valid), 16'h0);
    check("par_bad_busy", 16'(bus.busy), 16'h0);
    strobe(1'b1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
